// File: rtl/cipo_lvds_rx.sv
// CIPO LVDS receiver: differential termination, per-lane 2-flop
// synchroniser, programmable strobe delay for cable compensation and
// MSB-first deserialisation of one SPI frame per lane (SDR or DDR).
module cipo_lvds_rx #(
    parameter int NUM_CIPO  = 2,
    parameter int WORD_BITS = 16,
    parameter int DLY_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CIPO-1:0]           cipo_p,
    input  logic [NUM_CIPO-1:0]           cipo_n,
    input  logic                          frame_start,
    input  logic                          sclk_rise,
    input  logic                          sclk_fall,
    input  logic                          ddr_en,
    input  logic [DLY_W-1:0]              delay_sel,
    output logic [NUM_CIPO*WORD_BITS-1:0] data_a,
    output logic [NUM_CIPO*WORD_BITS-1:0] data_b,
    output logic                          data_valid,
    output logic                          frame_err
);

    localparam int DEPTH = (1 << DLY_W) - 1;
    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t state, state_n;

    // Differential receive. This expression stands in for the IBUFDS
    // primitive (LVDS_25, DIFF_TERM TRUE) placed on each pair.
    logic [NUM_CIPO-1:0] lane_raw;
    logic [NUM_CIPO-1:0] sync1;
    logic [NUM_CIPO-1:0] lane_s;

    assign lane_raw = cipo_p & ~cipo_n;

    // Two-flop synchroniser per lane
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            lane_s <= '0;
        end else begin
            sync1  <= lane_raw;
            lane_s <= sync1;
        end
    end

    // Strobe delay lines; tap 0 is the undelayed strobe
    logic [DEPTH-1:0] sr_start, sr_rise, sr_fall;
    logic [DEPTH:0]   line_start, line_rise, line_fall;
    logic [DLY_W-1:0] dly_q;
    logic             ddr_q;
    logic             d_start, d_rise, d_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_start <= '0;
            sr_rise  <= '0;
            sr_fall  <= '0;
        end else begin
            sr_start <= {sr_start[DEPTH-2:0], frame_start};
            sr_rise  <= {sr_rise[DEPTH-2:0], sclk_rise};
            sr_fall  <= {sr_fall[DEPTH-2:0], sclk_fall};
        end
    end

    assign line_start = {sr_start, frame_start};
    assign line_rise  = {sr_rise, sclk_rise};
    assign line_fall  = {sr_fall, sclk_fall};
    assign d_start    = line_start[dly_q];
    assign d_rise     = line_rise[dly_q];
    assign d_fall     = line_fall[dly_q];

    // Delay and mode settings are only picked up between frames
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
            ddr_q <= 1'b0;
        end else if (state == IDLE) begin
            dly_q <= delay_sel;
            ddr_q <= ddr_en;
        end
    end

    logic [CNT_W-1:0]     rise_cnt, fall_cnt, rise_n, fall_n;
    logic [WORD_BITS-1:0] shift_a [NUM_CIPO];
    logic [WORD_BITS-1:0] shift_b [NUM_CIPO];
    logic [WORD_BITS-1:0] sa_s    [NUM_CIPO];
    logic [WORD_BITS-1:0] sb_s    [NUM_CIPO];
    logic [WORD_BITS-1:0] sa_n    [NUM_CIPO];
    logic [WORD_BITS-1:0] sb_n    [NUM_CIPO];
    logic                 done, load, clear, err_n;

    // Next-state, sampling and frame completion. done looks at the counts
    // including this cycle's strobe, so the completed word (with its last
    // bit) is loaded in the same cycle that a coinciding d_start restarts.
    always_comb begin
        state_n = state;
        rise_n  = rise_cnt;
        fall_n  = fall_cnt;
        sa_s    = shift_a;
        sb_s    = shift_b;
        done    = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (d_start) begin
                    clear   = 1'b1;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (d_rise && rise_cnt != CNT_MAX) begin
                    for (int unsigned k = 0; k < NUM_CIPO; k++)
                        sa_s[k] = {shift_a[k][WORD_BITS-2:0], lane_s[k]};
                    rise_n = rise_cnt + CNT_ONE;
                end
                if (d_fall && ddr_q && fall_cnt != CNT_MAX) begin
                    for (int unsigned k = 0; k < NUM_CIPO; k++)
                        sb_s[k] = {shift_b[k][WORD_BITS-2:0], lane_s[k]};
                    fall_n = fall_cnt + CNT_ONE;
                end
                done = (rise_n == CNT_MAX) && (!ddr_q || fall_n == CNT_MAX);
                if (done) begin
                    load    = 1'b1;
                    state_n = IDLE;
                end
                if (d_start) begin
                    clear   = 1'b1;
                    err_n   = !done;
                    state_n = CAPTURE;
                end
            end
            default: state_n = IDLE;
        endcase

        sa_n = sa_s;
        sb_n = sb_s;
        if (clear) begin
            rise_n = '0;
            fall_n = '0;
            for (int unsigned k = 0; k < NUM_CIPO; k++) begin
                sa_n[k] = '0;
                sb_n[k] = '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Counters, shift registers and output words
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            data_a     <= '0;
            data_b     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            for (int unsigned k = 0; k < NUM_CIPO; k++) begin
                shift_a[k] <= '0;
                shift_b[k] <= '0;
            end
        end else begin
            rise_cnt   <= rise_n;
            fall_cnt   <= fall_n;
            data_valid <= load;
            frame_err  <= err_n;
            for (int unsigned k = 0; k < NUM_CIPO; k++) begin
                shift_a[k] <= sa_n[k];
                shift_b[k] <= sb_n[k];
                if (load) begin
                    data_a[k*WORD_BITS +: WORD_BITS] <= sa_s[k];
                    data_b[k*WORD_BITS +: WORD_BITS] <= ddr_q ? sb_s[k] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cipo_lvds_rx.sv
// Directed bench for cipo_lvds_rx: frames are scheduled cycle by cycle
// (frame_start at t=0, rise strobe for bit i at t=4+6i, fall at t=7+6i,
// pins carry the rise bit for t in [1+6i,3+6i] and the fall bit for
// t in [4+6i,6+6i], shifted later by the modelled cable skew).
module tb_cipo_lvds_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cipo_p, cipo_n;
    logic        frame_start, sclk_rise, sclk_fall, ddr_en;
    logic [3:0]  delay_sel;
    logic [31:0] data_a, data_b;
    logic        data_valid, frame_err;

    cipo_lvds_rx #(.NUM_CIPO(2), .WORD_BITS(16), .DLY_W(4)) dut (
        .clk(clk), .rst(rst), .cipo_p(cipo_p), .cipo_n(cipo_n),
        .frame_start(frame_start), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .ddr_en(ddr_en), .delay_sel(delay_sel),
        .data_a(data_a), .data_b(data_b),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame schedule
    int          nf;
    int          org [2];
    int          nb  [2];
    logic [15:0] wa0 [2], wa1 [2], wb0 [2], wb1 [2];
    int          skew, rst_at, snap_c;
    logic [1:0]  pv;

    // Observations
    int          n_valid, n_err, err_c;
    logic [31:0] va_a [4], va_b [4];
    int          va_c [4];
    logic [31:0] snap_a, snap_b;
    logic        snap_v, snap_e;

    task automatic set_frame(input int f, input int o, input int n,
                             input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] b0, input logic [15:0] b1);
        org[f] = o; nb[f] = n;
        wa0[f] = a0; wa1[f] = a1; wb0[f] = b0; wb1[f] = b1;
    endtask

    task automatic sample(input int c);
        if (data_valid) begin
            if (n_valid < 4) begin
                va_a[n_valid] = data_a;
                va_b[n_valid] = data_b;
                va_c[n_valid] = c;
            end
            n_valid++;
        end
        if (frame_err) begin
            if (n_err == 0) err_c = c;
            n_err++;
        end
        if (c == snap_c) begin
            snap_a = data_a; snap_b = data_b;
            snap_v = data_valid; snap_e = frame_err;
        end
    endtask

    task automatic drive(input int c);
        int t, tp, i, ph;
        frame_start = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
        rst = (rst_at >= 0) && (c == rst_at || c == rst_at + 1);
        for (int f = 0; f < nf; f++) begin
            t = c - org[f];
            if (t == 0) frame_start = 1'b1;
            if (t >= 4 && (t - 4) % 6 == 0 && (t - 4) / 6 < nb[f]) sclk_rise = 1'b1;
            if (t >= 7 && (t - 7) % 6 == 0 && (t - 7) / 6 < nb[f]) sclk_fall = 1'b1;
            tp = t - skew;
            if (tp >= 1) begin
                i  = (tp - 1) / 6;
                ph = (tp - 1) % 6;
                if (i < 16) begin
                    pv[0] = (ph < 3) ? wa0[f][15-i] : wb0[f][15-i];
                    pv[1] = (ph < 3) ? wa1[f][15-i] : wb1[f][15-i];
                end
            end
        end
        cipo_p = pv;
        cipo_n = ~pv;
    endtask

    task automatic play(input logic ddr, input logic [3:0] dly, input int len);
        ddr_en = ddr; delay_sel = dly; pv = 2'b00;
        frame_start = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0; rst = 1'b0;
        cipo_p = 2'b00; cipo_n = 2'b11;
        repeat (4) @(negedge clk);
        n_valid = 0; n_err = 0; err_c = -1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            sample(c);
            drive(c);
        end
        @(negedge clk);
        sample(len);
        frame_start = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0; rst = 1'b0;
        pv = 2'b00; cipo_p = 2'b00; cipo_n = 2'b11;
    endtask

    initial begin
        rst = 1'b1; cipo_p = 2'b00; cipo_n = 2'b11;
        frame_start = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
        ddr_en = 1'b0; delay_sel = 4'd0;
        skew = 0; rst_at = -1; snap_c = -1; nf = 0;
        repeat (4) @(negedge clk);
        check("rst_data_a", data_a, 32'h0);
        check("rst_data_b", data_b, 32'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
        rst = 1'b0;

        // SDR, no delay
        nf = 1; skew = 0;
        set_frame(0, 0, 16, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234);
        play(1'b0, 4'd0, 120);
        check("sdr_count", n_valid, 1);
        check("sdr_data_a", va_a[0], 32'h1234_A5C3);
        check("sdr_data_b", va_b[0], 32'h0);
        check("sdr_latency", va_c[0], 95);
        check("sdr_err", n_err, 0);

        // Cable skew of 3 cycles, compensated and not
        skew = 3;
        set_frame(0, 0, 16, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);
        play(1'b0, 4'd3, 125);
        check("dly3_count", n_valid, 1);
        check("dly3_data_a", va_a[0], 32'h7FFE_8001);
        check("dly3_latency", va_c[0], 98);
        play(1'b0, 4'd0, 125);
        check("dly0_count", n_valid, 1);
        check("dly0_data_a", va_a[0], 32'h3FFF_4000);
        skew = 0;

        // DDR
        set_frame(0, 0, 16, 16'hFFFF, 16'h0F0F, 16'h0000, 16'hF0F0);
        play(1'b1, 4'd0, 120);
        check("ddr_count", n_valid, 1);
        check("ddr_data_a", va_a[0], 32'h0F0F_FFFF);
        check("ddr_data_b", va_b[0], 32'hF0F0_0000);
        check("ddr_latency", va_c[0], 98);

        // Abort after 7 bits, then a full frame
        nf = 2;
        set_frame(0, 0, 7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_frame(1, 44, 16, 16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00);
        play(1'b0, 4'd0, 164);
        check("abort_err_count", n_err, 1);
        check("abort_err_cycle", err_c, 45);
        check("abort_valid_count", n_valid, 1);
        check("abort_data_a", va_a[0], 32'hFF00_00FF);
        check("abort_data_b", va_b[0], 32'h0);
        check("abort_latency", va_c[0], 139);

        // Back-to-back: second frame_start on the completing strobe
        set_frame(0, 0, 16, 16'hC0DE, 16'hBEEF, 16'hC0DE, 16'hBEEF);
        set_frame(1, 94, 16, 16'h1357, 16'h2468, 16'h1357, 16'h2468);
        play(1'b0, 4'd0, 214);
        check("b2b_count", n_valid, 2);
        check("b2b_err", n_err, 0);
        check("b2b_data1", va_a[0], 32'hBEEF_C0DE);
        check("b2b_cycle1", va_c[0], 95);
        check("b2b_data2", va_a[1], 32'h2468_1357);
        check("b2b_cycle2", va_c[1], 189);

        // Reset after 10 strobes, then a fresh frame
        set_frame(0, 0, 10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_frame(1, 70, 16, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5);
        rst_at = 62; snap_c = 64;
        play(1'b0, 4'd0, 190);
        check("mrst_data_a", snap_a, 32'h0);
        check("mrst_data_b", snap_b, 32'h0);
        check("mrst_valid", snap_v, 1'b0);
        check("mrst_err", snap_e, 1'b0);
        check("mrst_count", n_valid, 1);
        check("mrst_err_count", n_err, 0);
        check("mrst_data", va_a[0], 32'hA5A5_5A5A);
        check("mrst_cycle", va_c[0], 165);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
